logic_unit_arbiter: RTL

//  Shares one combinational bitwise logic unit (AND/OR/XOR/NAND) between N

---
 rtl/logic_op_pkg.sv | 30 +++
 rtl/logic_op_unit.sv | 24 ++
 rtl/logic_unit_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// logic_op_pkg
//   Shared definitions for the bitwise logic unit: opcode width, opcode
//   encodings and the per-bit evaluation function used by both the datapath
//   and any reference model.
//   Opcodes: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
package logic_op_pkg;

   localparam int OP_W = 2;

   localparam logic [OP_W-1:0] OP_AND  = 2'b00;
   localparam logic [OP_W-1:0] OP_OR   = 2'b01;
   localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
   localparam logic [OP_W-1:0] OP_NAND = 2'b11;

   // Evaluates one bit position. Width-independent, so any operand width is
   // handled by applying it across every bit.
   function automatic logic logic_op(input logic [OP_W-1:0] op,
                                     input logic            a,
                                     input logic            b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = ~(a & b);  // OP_NAND
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit
//   Purely combinational bitwise logic unit. Applies logic_op() to every bit
//   of the operands.
//   Ports:
//     op  in   OP_W    opcode (AND/OR/XOR/NAND)
//     a   in   WIDTH   operand a
//     b   in   WIDTH   operand b
//     z   out  WIDTH   result
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] z
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign z[i] = logic_op(op, a[i], b[i]);
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one logic_op_unit between N requesters with round-robin
//   arbitration. At most one request is granted per cycle; its result is
//   registered together with the winner's index and offered on a
//   valid/ready response port.
//   Ports:
//     clk        in   1        clock, rising edge
//     rstn       in   1        async active-low reset
//     req        in   N        pending-operation flags
//     a_bus      in   N*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//     b_bus      in   N*WIDTH  operand b, requester i at [i*WIDTH +: WIDTH]
//     op_bus     in   N*2      opcode, requester i at [i*2 +: 2]
//     gnt        out  N        one-hot grant (combinational), 0 when none
//     rsp_valid  out  1        registered result available
//     rsp_ready  in   1        consumer accepts the result
//     rsp_id     out  IDW      owner of rsp_z
//     rsp_z      out  WIDTH    registered result
module logic_unit_arbiter
   import logic_op_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] a_bus,
   input  logic [N*WIDTH-1:0] b_bus,
   input  logic [N*OP_W-1:0]  op_bus,
   output logic [N-1:0]       gnt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [WIDTH-1:0]   rsp_z
);

   logic [IDW-1:0]   ptr;       // highest-priority requester this cycle
   logic             adv;       // response slot free or being drained
   logic             grant_any;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   ptr_nxt;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [OP_W-1:0]  op_sel;
   logic [WIDTH-1:0] z_sel;
   int               idx;

   assign adv = !rsp_valid || rsp_ready;

   // Rotating priority search starting at ptr; the first hit also steers the
   // operand mux so the single logic unit sees only the winner's operands.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // one unassigned, which would otherwise infer a latch.
      gnt       = '0;
      grant_any = 1'b0;
      win       = '0;
      a_sel     = '0;
      b_sel     = '0;
      op_sel    = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (rstn && adv && !grant_any && req[idx]) begin
            grant_any = 1'b1;
            gnt[idx]  = 1'b1;
            win       = IDW'(idx);
            a_sel     = a_bus[idx*WIDTH +: WIDTH];
            b_sel     = b_bus[idx*WIDTH +: WIDTH];
            op_sel    = op_bus[idx*OP_W +: OP_W];
         end
      end
   end

   // Next search starts just past the winner; with N=1 this is always 0.
   assign ptr_nxt = IDW'((int'(win) + 1) % N);

   logic_op_unit #(.WIDTH(WIDTH)) u_op (
      .op (op_sel),
      .a  (a_sel),
      .b  (b_sel),
      .z  (z_sel)
   );

   // Response register. Accepting the current response and capturing the
   // next grant happen on the same edge, giving one op per cycle.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: registered state uses nonblocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_z     <= '0;
         ptr       <= '0;
      end else if (adv) begin
         if (grant_any) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win;
            rsp_z     <= z_sel;
            ptr       <= ptr_nxt;
         end else begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
